// File: rtl/tag_switch_debounce_irq.sv
// Slide-switch controller: synchronise, debounce, capture edges, raise a maskable irq.
// Define TAG_SWITCH_DEBOUNCE_EN to build the tick-based debounce filter; otherwise switches pass straight through.
module tag_switch_debounce_irq #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrIrqMask = 2'd1;
  localparam logic [1:0] AddrEdgeCap = 2'd2;
  localparam logic [1:0] AddrCtrl    = 2'd3;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable, stable_d_q;
  logic [WIDTH-1:0] edge_det, w1c;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q;
  logic             mode_q;
  logic [31:0]      rdata_d;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef TAG_SWITCH_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CntW-1:0]  cnt_q;
  logic             tick;
  logic [WIDTH-1:0] samp_q, stable_q, agree;

  assign tick  = (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));
  assign agree = ~(sync2_q ^ samp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A bit only moves once two consecutive tick samples agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q   <= '0;
      stable_q <= '0;
    end else if (tick) begin
      samp_q   <= sync2_q;
      stable_q <= (stable_q & ~agree) | (sync2_q & agree);
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d_q <= '0;
    end else begin
      stable_d_q <= stable;
    end
  end

  assign edge_det = (stable & ~stable_d_q) | (~stable & stable_d_q & {WIDTH{mode_q}});

  // New edges take priority over a same-cycle W1C.
  assign w1c       = (write && (address == AddrEdgeCap)) ? writedata[WIDTH-1:0] : '0;
  assign edgecap_d = (edgecap_q & ~w1c) | edge_det;

  always_comb begin
    rdata_d = '0;
    unique case (address)
      AddrData:    rdata_d[WIDTH-1:0] = stable;
      AddrIrqMask: rdata_d[WIDTH-1:0] = irqmask_q;
      AddrEdgeCap: rdata_d[WIDTH-1:0] = edgecap_q;
      AddrCtrl:    rdata_d[0]         = mode_q;
      default:     rdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q <= '0;
      mode_q    <= 1'b0;
      edgecap_q <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      if (write && (address == AddrIrqMask)) irqmask_q <= writedata[WIDTH-1:0];
      if (write && (address == AddrCtrl))    mode_q    <= writedata[0];
      edgecap_q <= edgecap_d;
      irq       <= |(edgecap_q & irqmask_q);
      readdata  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_tag_switch_debounce_irq.sv
// Directed bench: stimulus scheduled on absolute cycles after reset, checks drained by a scoreboard monitor.
module tb_tag_switch_debounce_irq;

  // Posedges from an in_port change (phase 2 of the 4-cycle prescaler) to stable changing.
`ifdef TAG_SWITCH_DEBOUNCE_EN
  localparam int Lat = 6;
`else
  localparam int Lat = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  in_port;
  logic        irq;

  tag_switch_debounce_irq #(
    .WIDTH          (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .in_port  (in_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t exp_q[$];
  chk_t mon_c;
  int   cyc = 0;
  int   issue_n = 0;
  int   pend_n = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [31:0] mon_act;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
    pend_n <= issue_n;
  end

  // Monitor: outputs registered at the posedge after a check was issued.
  always @(negedge clk) begin
    for (int i = 0; i < pend_n; i++) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_underflow: got no expected entry, required one");
      end else begin
        mon_c   = exp_q.pop_front();
        mon_act = mon_c.is_irq ? {31'b0, irq} : readdata;
        if (mon_act !== mon_c.exp) begin
          tests_failed++;
          $display("FAIL %s: got %h, required %h (cycle %0d)", mon_c.name, mon_act, mon_c.exp, cyc);
        end
      end
    end
  end

  task automatic goto(input int x);
    if (cyc > x - 1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sched: got cycle %0d, required at most %0d", cyc, x - 1);
    end
    while (cyc < x - 1) begin
      @(negedge clk);
      write   = 1'b0;
      issue_n = 0;
    end
  endtask

  task automatic rd(input int x, input logic [1:0] a, input logic [31:0] e, input string nm);
    goto(x);
    address = a;
    exp_q.push_back('{1'b0, e, nm});
    issue_n++;
  endtask

  task automatic chk_irq(input int x, input logic e, input string nm);
    goto(x);
    exp_q.push_back('{1'b1, {31'b0, e}, nm});
    issue_n++;
  endtask

  task automatic wr(input int x, input logic [1:0] a, input logic [31:0] d);
    goto(x);
    address   = a;
    writedata = d;
    write     = 1'b1;
  endtask

  task automatic set_in(input int x, input logic [9:0] v);
    goto(x);
    in_port = v;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_port   = 10'h3FF;
    address   = 2'd0;
    write     = 1'b0;
    writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state with switches held high
    rd(1, 2'd0, 32'h0, "rst_data");
    chk_irq(1, 1'b0, "rst_irq");
    rd(2, 2'd1, 32'h0, "rst_irqmask");
    rd(3, 2'd2, 32'h0, "rst_edgecap");
    rd(4, 2'd3, 32'h0, "rst_ctrl");
    rd(13, 2'd0, 32'h3FF, "rst_data_settled");
    rd(14, 2'd2, 32'h3FF, "rst_rise_captured");
    wr(15, 2'd2, 32'h3FF);
    rd(17, 2'd2, 32'h0, "edgecap_w1c_all");
    set_in(18, 10'h000);
    rd(28, 2'd0, 32'h0, "data_released");
    rd(29, 2'd2, 32'h0, "mode0_fall_ignored_all");

`ifdef TAG_SWITCH_DEBOUNCE_EN
    // 3-clock glitch on bit 0 must be filtered
    set_in(30, 10'h001);
    set_in(33, 10'h000);
    rd(45, 2'd0, 32'h0, "glitch_data");
    rd(46, 2'd2, 32'h0, "glitch_edgecap");
`else
    // Pass-through: 1-clock pulse on bit 9 seen 3 clocks later and captured
    set_in(30, 10'h200);
    rd(30, 2'd0, 32'h0, "pulse_data_early");
    set_in(31, 10'h000);
    rd(31, 2'd0, 32'h0, "pulse_data_sync");
    rd(32, 2'd0, 32'h200, "pulse_data_seen");
    rd(33, 2'd0, 32'h0, "pulse_data_gone");
    rd(34, 2'd2, 32'h200, "pulse_captured");
    wr(35, 2'd2, 32'h200);
    rd(37, 2'd2, 32'h0, "pulse_cleared");
`endif

    // Interrupt on bit 0 rise
    wr(50, 2'd1, 32'h001);
    rd(51, 2'd1, 32'h001, "irqmask_rb");
    set_in(54, 10'h001);
    rd(54 + Lat, 2'd0, 32'h0, "data_pre_rise");
    rd(55 + Lat, 2'd0, 32'h001, "data_post_rise");
    chk_irq(55 + Lat, 1'b0, "irq_not_yet");
    chk_irq(56 + Lat, 1'b1, "irq_assert");
    rd(56 + Lat, 2'd2, 32'h001, "edgecap_bit0");
    wr(70, 2'd2, 32'h001);
    chk_irq(70, 1'b1, "irq_held");
    chk_irq(71, 1'b0, "irq_w1c_drop");
    rd(72, 2'd2, 32'h0, "edgecap_w1c_bit0");

    // Mode: release of bit 3 ignored with CTRL=0, captured with CTRL=1
    set_in(74, 10'h009);
    wr(84, 2'd2, 32'h008);
    rd(85, 2'd2, 32'h0, "mode_setup_clear");
    set_in(86, 10'h001);
    rd(96, 2'd2, 32'h0, "mode0_fall_ignored");
    wr(97, 2'd3, 32'h1);
    rd(98, 2'd3, 32'h1, "ctrl_rb");
    set_in(98, 10'h009);
    wr(106, 2'd2, 32'h008);
    rd(108, 2'd2, 32'h0, "mode1_rise_cleared");
    set_in(110, 10'h001);
    rd(120, 2'd2, 32'h008, "mode1_fall_captured");

    // Mask change with a capture already pending
    wr(121, 2'd1, 32'h009);
    chk_irq(121, 1'b0, "irq_pre_mask");
    chk_irq(122, 1'b1, "irq_mask_set");
    wr(123, 2'd1, 32'h001);
    chk_irq(124, 1'b0, "irq_mask_clr");
    wr(125, 2'd2, 32'h008);

    // W1C of bit 5 on the very clock its fall edge is captured
    set_in(126, 10'h021);
    set_in(138, 10'h001);
    wr(139 + Lat, 2'd2, 32'h020);
    rd(147, 2'd2, 32'h020, "set_wins");
    wr(148, 2'd2, 32'h020);
    rd(150, 2'd2, 32'h0, "w1c_after_collision");

    goto(160);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
